// File: rtl/dice_pkg.sv
// Shared types, constants and helpers for the dice roll sequencer.
package dice_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ROLL = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam logic [15:0] LFSR_MASK = 16'hB400;
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [6:0]  SEG_BLANK = 7'h7F;
   localparam logic [6:0]  SIDES_MIN = 7'd2;
   localparam logic [6:0]  SIDES_MAX = 7'd99;

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
   endfunction

   function automatic logic [6:0] clamp_sides(input logic [6:0] s);
      if (s < SIDES_MIN) return SIDES_MIN;
      if (s > SIDES_MAX) return SIDES_MAX;
      return s;
   endfunction

   // Compare-subtract split into {tens, ones}; nine passes cover 0..99.
   function automatic logic [7:0] bin2bcd(input logic [6:0] v);
      logic [6:0] rem;
      logic [3:0] tens;
      rem  = v;
      tens = 4'd0;
      for (int i = 0; i < 9; i++) begin
         if (rem >= 7'd10) begin
            rem  = rem - 7'd10;
            tens = tens + 4'd1;
         end
      end
      return {tens, rem[3:0]};
   endfunction

endpackage

// File: rtl/seg7_digit_decoder.sv
// Decimal digit to active-low seven-segment pattern, bit0 = a .. bit6 = g.
module seg7_digit_decoder
   import dice_pkg::*;
(
   input  logic [3:0] i_digit,
   output logic [6:0] o_seg
);

   always_comb begin
      o_seg = SEG_BLANK;
      case (i_digit)
         4'd0: o_seg = 7'b1000000;
         4'd1: o_seg = 7'b1111001;
         4'd2: o_seg = 7'b0100100;
         4'd3: o_seg = 7'b0110000;
         4'd4: o_seg = 7'b0011001;
         4'd5: o_seg = 7'b0010010;
         4'd6: o_seg = 7'b0000010;
         4'd7: o_seg = 7'b1111000;
         4'd8: o_seg = 7'b0000000;
         4'd9: o_seg = 7'b0010000;
         default: o_seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/dice_roll_sequencer.sv
// Debounced dice roller with decelerating animation and CPU/sequencer HEX arbitration.
// Define DICE_LED_BAR_EN to add the led_bar roll-progress output.
module dice_roll_sequencer
   import dice_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int TICK_START      = 2_500_000,
   parameter int TICK_INC        = 1_250_000,
   parameter int NUM_STEPS       = 16,
   parameter int HOLD_CYCLES     = 150_000_000
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       roll_key_n,
   input  logic [6:0] sides,
   input  logic       cpu_hex_req,
   input  logic [6:0] cpu_hex0,
   input  logic [6:0] cpu_hex1,
   output logic [6:0] hex0,
   output logic [6:0] hex1,
   output logic       busy,
   output logic [6:0] result,
   output logic       result_valid
`ifdef DICE_LED_BAR_EN
   ,
   output logic [9:0] led_bar
`endif
);

   localparam logic [31:0] DB_LAST      = 32'(DEBOUNCE_CYCLES - 1);
   localparam logic [31:0] TICK_START_W = 32'(TICK_START);
   localparam logic [31:0] TICK_INC_W   = 32'(TICK_INC);
   localparam logic [31:0] STEP_LAST    = 32'(NUM_STEPS - 1);
   localparam logic [31:0] HOLD_LAST    = 32'(HOLD_CYCLES - 1);

   logic        r_key_s1, r_key_s2, r_key_stable;
   logic [31:0] r_db_cnt;
   logic [15:0] r_lfsr;
   state_t      r_state, w_state_nxt;
   logic [31:0] r_tick, r_period, r_step, r_hold_cnt;
   logic [6:0]  r_sides_q, r_disp_val, r_result;
   logic        r_result_valid;

   logic        w_db_diff, w_db_accept, w_press;
   logic        w_enter_roll, w_step_upd, w_finish;
   logic [22:0] w_product;
   logic [6:0]  w_draw;
   logic [7:0]  w_bcd;
   logic [6:0]  w_seg_ones, w_seg_tens, w_seq_hex0, w_seq_hex1;

   // Any difference from the accepted level must persist DEBOUNCE_CYCLES to be taken.
   assign w_db_diff   = (r_key_s2 != r_key_stable);
   assign w_db_accept = w_db_diff && (r_db_cnt == DB_LAST);
   assign w_press     = w_db_accept && !r_key_s2;

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         r_key_s1     <= 1'b1;
         r_key_s2     <= 1'b1;
         r_key_stable <= 1'b1;
         r_db_cnt     <= 32'd0;
      end else begin
         r_key_s1 <= roll_key_n;
         r_key_s2 <= r_key_s1;
         if (!w_db_diff) begin
            r_db_cnt <= 32'd0;
         end else if (w_db_accept) begin
            r_key_stable <= r_key_s2;
            r_db_cnt     <= 32'd0;
         end else begin
            r_db_cnt <= r_db_cnt + 32'd1;
         end
      end
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) r_lfsr <= LFSR_SEED;
      else       r_lfsr <= lfsr_next(r_lfsr);
   end

   assign w_product = {7'd0, r_lfsr} * {16'd0, r_sides_q};
   assign w_draw    = 7'(w_product >> 16) + 7'd1;

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_enter_roll = 1'b0;
      w_step_upd   = 1'b0;
      w_finish     = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_press) begin
               w_state_nxt  = ROLL;
               w_enter_roll = 1'b1;
            end
         end
         ROLL: begin
            if (r_tick == 32'd1) begin
               w_step_upd = 1'b1;
               if (r_step == STEP_LAST) begin
                  w_finish    = 1'b1;
                  w_state_nxt = HOLD;
               end
            end
         end
         HOLD: begin
            if (w_press) begin
               w_state_nxt  = ROLL;
               w_enter_roll = 1'b1;
            end else if (r_hold_cnt == HOLD_LAST) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         r_tick         <= 32'd0;
         r_period       <= 32'd0;
         r_step         <= 32'd0;
         r_hold_cnt     <= 32'd0;
         r_sides_q      <= SIDES_MIN;
         r_disp_val     <= 7'd0;
         r_result       <= 7'd0;
         r_result_valid <= 1'b0;
      end else begin
         r_result_valid <= w_finish;
         if (w_enter_roll) begin
            r_tick    <= TICK_START_W;
            r_period  <= TICK_START_W;
            r_step    <= 32'd0;
            r_sides_q <= clamp_sides(sides);
         end else if (r_state == ROLL) begin
            if (w_step_upd) begin
               r_disp_val <= w_draw;
               r_step     <= r_step + 32'd1;
               r_period   <= r_period + TICK_INC_W;
               r_tick     <= r_period + TICK_INC_W;
            end else begin
               r_tick <= r_tick - 32'd1;
            end
         end
         if (w_finish) r_result <= w_draw;
         r_hold_cnt <= (r_state == HOLD) ? r_hold_cnt + 32'd1 : 32'd0;
      end
   end

   // A display value of zero only occurs before the first roll and shows blank.
   assign w_bcd = bin2bcd(r_disp_val);

   seg7_digit_decoder u_seg_ones (
      .i_digit (w_bcd[3:0]),
      .o_seg   (w_seg_ones)
   );

   seg7_digit_decoder u_seg_tens (
      .i_digit (w_bcd[7:4]),
      .o_seg   (w_seg_tens)
   );

   assign w_seq_hex0 = (r_disp_val == 7'd0) ? SEG_BLANK : w_seg_ones;
   assign w_seq_hex1 = (w_bcd[7:4] == 4'd0) ? SEG_BLANK : w_seg_tens;

   always_comb begin
      hex0 = w_seq_hex0;
      hex1 = w_seq_hex1;
      if ((r_state == IDLE) && cpu_hex_req) begin
         hex0 = cpu_hex0;
         hex1 = cpu_hex1;
      end
   end

   assign busy         = (r_state == ROLL);
   assign result       = r_result;
   assign result_valid = r_result_valid;

`ifdef DICE_LED_BAR_EN
   localparam logic [31:0] NUM_STEPS_W = 32'(NUM_STEPS);
   logic [31:0] w_lit;

   assign w_lit = (r_step * 32'd10) / NUM_STEPS_W;

   always_comb begin
      led_bar = 10'd0;
      if (r_state == ROLL)      led_bar = ~(10'h3FF << w_lit);
      else if (r_state == HOLD) led_bar = 10'h3FF;
   end
`endif

endmodule

// File: tb/tb_dice_roll_sequencer.sv
// Scoreboard bench for dice_roll_sequencer with shortened timing parameters.
module tb_dice_roll_sequencer;

   localparam int DB = 4;
   localparam int TS = 8;
   localparam int TI = 2;
   localparam int NS = 4;
   localparam int HC = 20;

   logic       clk = 1'b0;
   logic       rst;
   logic       key_n;
   logic [6:0] sides;
   logic       cpu_req;
   logic [6:0] cpu0, cpu1;
   logic [6:0] hex0, hex1, result;
   logic       busy, rv;
`ifdef DICE_LED_BAR_EN
   logic [9:0] led_bar;
`endif

   int         total = 0;
   int         bad = 0;
   int         rv_count = 0;
   int         last_val = 0;
   int         exp_q[$];
   logic [15:0] m_lfsr;

   always #10 clk = ~clk;

   dice_roll_sequencer #(
      .DEBOUNCE_CYCLES (DB),
      .TICK_START      (TS),
      .TICK_INC        (TI),
      .NUM_STEPS       (NS),
      .HOLD_CYCLES     (HC)
   ) dut (
      .CLOCK_50     (clk),
      .reset        (rst),
      .roll_key_n   (key_n),
      .sides        (sides),
      .cpu_hex_req  (cpu_req),
      .cpu_hex0     (cpu0),
      .cpu_hex1     (cpu1),
      .hex0         (hex0),
      .hex1         (hex1),
      .busy         (busy),
      .result       (result),
      .result_valid (rv)
`ifdef DICE_LED_BAR_EN
      ,
      .led_bar      (led_bar)
`endif
   );

   // Reference LFSR: Galois, mask B400, seeded by reset.
   always @(posedge clk or posedge rst) begin
      if (rst) m_lfsr <= 16'hACE1;
      else     m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
   end

   always @(negedge clk) begin
      if (rv === 1'b1) rv_count++;
   end

   initial begin
      #(100000 * 20);
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   function automatic logic [6:0] seg_of(input int d);
      case (d)
         0: return 7'h40;
         1: return 7'h79;
         2: return 7'h24;
         3: return 7'h30;
         4: return 7'h19;
         5: return 7'h12;
         6: return 7'h02;
         7: return 7'h78;
         8: return 7'h00;
         9: return 7'h10;
         default: return 7'h7F;
      endcase
   endfunction

   function automatic logic [6:0] exp_h0(input int v);
      return (v == 0) ? 7'h7F : seg_of(v % 10);
   endfunction

   function automatic logic [6:0] exp_h1(input int v);
      return (v < 10) ? 7'h7F : seg_of(v / 10);
   endfunction

`ifdef DICE_LED_BAR_EN
   function automatic logic [9:0] bar_mask(input int n);
      logic [9:0] m;
      m = 10'd0;
      for (int i = 0; i < n && i < 10; i++) m[i] = 1'b1;
      return m;
   endfunction
`endif

   task automatic press(input string name);
      int n;
      n = 0;
      @(negedge clk);
      key_n = 1'b0;
      while (busy !== 1'b1 && n < 12) begin
         @(negedge clk);
         n++;
      end
      key_n = 1'b1;
      total++;
      if (busy !== 1'b1 || n > DB + 2)
         $display("FAIL press_%s: busy=%b after %0d cycles, want 1 within %0d", name, busy, n, DB + 2);
      if (busy !== 1'b1 || n > DB + 2) bad++;
   endtask

   // Called on the first negedge with busy high; walks nsteps display updates.
   task automatic roll_check(input int sraw, input int nsteps);
      int sq, p, ev;
      sq = (sraw < 2) ? 2 : ((sraw > 99) ? 99 : sraw);
      p = TS;
`ifdef DICE_LED_BAR_EN
      total++;
      if (led_bar !== 10'd0) begin
         bad++;
         $display("FAIL led_entry: got %h want 000", led_bar);
      end
`endif
      for (int k = 0; k < nsteps; k++) begin
         repeat (p - 1) @(negedge clk);
         total++;
         if (hex0 !== exp_h0(last_val) || hex1 !== exp_h1(last_val) || busy !== 1'b1 || rv !== 1'b0) begin
            bad++;
            $display("FAIL roll_early step=%0d: hex1=%h hex0=%h busy=%b rv=%b want %h %h 1 0",
                     k, hex1, hex0, busy, rv, exp_h1(last_val), exp_h0(last_val));
         end
         exp_q.push_back(((int'(m_lfsr) * sq) >> 16) + 1);
         @(negedge clk);
         ev = exp_q.pop_front();
         total++;
         if (hex0 !== exp_h0(ev) || hex1 !== exp_h1(ev)) begin
            bad++;
            $display("FAIL roll_update step=%0d: hex1=%h hex0=%h want %h %h (value %0d)",
                     k, hex1, hex0, exp_h1(ev), exp_h0(ev), ev);
         end
         last_val = ev;
         if (k == NS - 1) begin
            total++;
            if (rv !== 1'b1 || result !== 7'(ev) || busy !== 1'b0) begin
               bad++;
               $display("FAIL roll_finish: rv=%b result=%0d busy=%b want 1 %0d 0", rv, result, busy, ev);
            end
`ifdef DICE_LED_BAR_EN
            total++;
            if (led_bar !== 10'h3FF) begin
               bad++;
               $display("FAIL led_hold: got %h want 3ff", led_bar);
            end
`endif
         end else begin
            total++;
            if (rv !== 1'b0 || busy !== 1'b1) begin
               bad++;
               $display("FAIL roll_step step=%0d: rv=%b busy=%b want 0 1", k, rv, busy);
            end
`ifdef DICE_LED_BAR_EN
            total++;
            if (led_bar !== bar_mask(((k + 1) * 10) / NS)) begin
               bad++;
               $display("FAIL led_step step=%0d: got %h want %h", k, led_bar, bar_mask(((k + 1) * 10) / NS));
            end
`endif
         end
         p += TI;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      key_n = 1'b1;
      sides = 7'd6;
      cpu_req = 1'b0;
      cpu0 = 7'h40;
      cpu1 = 7'h79;
      repeat (3) @(negedge clk);
      total++;
      if (hex0 !== 7'h7F || hex1 !== 7'h7F) begin
         bad++;
         $display("FAIL reset_hex: hex1=%h hex0=%h want 7f 7f", hex1, hex0);
      end
      total++;
      if (busy !== 1'b0 || rv !== 1'b0 || result !== 7'd0) begin
         bad++;
         $display("FAIL reset_ctrl: busy=%b rv=%b result=%0d want 0 0 0", busy, rv, result);
      end
      total++;
      if (dut.r_lfsr !== 16'hACE1) begin
         bad++;
         $display("FAIL reset_lfsr: got %h want ace1", dut.r_lfsr);
      end
`ifdef DICE_LED_BAR_EN
      total++;
      if (led_bar !== 10'd0) begin
         bad++;
         $display("FAIL reset_led: got %h want 000", led_bar);
      end
`endif
      rst = 1'b0;
      last_val = 0;
   endtask

   task automatic test_bounce;
      int   rises;
      logic pb;
      rises = 0;
      pb = busy;
      for (int i = 0; i < 10; i++) begin
         key_n = ~key_n;
         repeat (2) begin
            @(negedge clk);
            if (busy && !pb) rises++;
            pb = busy;
         end
      end
      total++;
      if (rises !== 0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL bounce_early: rises=%0d busy=%b want 0 0", rises, busy);
      end
      key_n = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         if (busy && !pb) rises++;
         pb = busy;
         if (i == 5) begin
            total++;
            if (busy !== 1'b0) begin
               bad++;
               $display("FAIL bounce_premature: busy=%b want 0", busy);
            end
         end
      end
      key_n = 1'b1;
      total++;
      if (busy !== 1'b1 || rises !== 1) begin
         bad++;
         $display("FAIL bounce_press: busy=%b rises=%0d want 1 1", busy, rises);
      end
      roll_check(6, NS);
      total++;
      if (result < 7'd1 || result > 7'd6 || hex1 !== 7'h7F) begin
         bad++;
         $display("FAIL roll_range6: result=%0d hex1=%h want 1..6 7f", result, hex1);
      end
   endtask

   task automatic test_arbitration;
      cpu_req = 1'b1;
      cpu0 = 7'h40;
      cpu1 = 7'h79;
      repeat (HC - 1) @(negedge clk);
      total++;
      if (hex0 !== exp_h0(last_val) || hex1 !== exp_h1(last_val)) begin
         bad++;
         $display("FAIL arb_hold: hex1=%h hex0=%h want %h %h", hex1, hex0, exp_h1(last_val), exp_h0(last_val));
      end
      @(negedge clk);
      total++;
      if (hex0 !== 7'h40 || hex1 !== 7'h79) begin
         bad++;
         $display("FAIL arb_idle: hex1=%h hex0=%h want 79 40", hex1, hex0);
      end
      cpu0 = 7'h12;
      #1;
      total++;
      if (hex0 !== 7'h12) begin
         bad++;
         $display("FAIL arb_comb: hex0=%h want 12", hex0);
      end
      cpu_req = 1'b0;
      #1;
      total++;
      if (hex0 !== exp_h0(last_val) || hex1 !== exp_h1(last_val)) begin
         bad++;
         $display("FAIL arb_release: hex1=%h hex0=%h want %h %h", hex1, hex0, exp_h1(last_val), exp_h0(last_val));
      end
   endtask

   task automatic test_clamp;
      cpu_req = 1'b1;
      sides = 7'd0;
      press("clamp_lo");
      roll_check(0, NS);
      total++;
      if (result < 7'd1 || result > 7'd2) begin
         bad++;
         $display("FAIL clamp_lo: result=%0d want 1..2", result);
      end
      repeat (HC + 2) @(negedge clk);
      sides = 7'd120;
      press("clamp_hi");
      roll_check(120, NS);
      total++;
      if (result < 7'd1 || result > 7'd99) begin
         bad++;
         $display("FAIL clamp_hi: result=%0d want 1..99", result);
      end
      repeat (HC + 2) @(negedge clk);
      cpu_req = 1'b0;
   endtask

   task automatic test_ignore;
      sides = 7'd6;
      press("ignore");
      fork
         roll_check(6, NS);
         begin
            repeat (3) @(negedge clk);
            sides = 7'd2;
            repeat (7) @(negedge clk);
            key_n = 1'b0;
            repeat (8) @(negedge clk);
            key_n = 1'b1;
         end
      join
      total++;
      if (result < 7'd1 || result > 7'd6) begin
         bad++;
         $display("FAIL ignore_range: result=%0d want 1..6", result);
      end
      sides = 7'd5;
      press("in_hold");
      roll_check(5, NS);
      repeat (HC + 2) @(negedge clk);
   endtask

   task automatic test_reset_midroll;
      int rvc;
      sides = 7'd6;
      press("midroll");
      roll_check(6, 2);
      rst = 1'b1;
      #1;
      rvc = rv_count;
      total++;
      if (busy !== 1'b0 || hex0 !== 7'h7F || hex1 !== 7'h7F || rv !== 1'b0 || result !== 7'd0) begin
         bad++;
         $display("FAIL midroll_reset: busy=%b hex1=%h hex0=%h rv=%b result=%0d want 0 7f 7f 0 0",
                  busy, hex1, hex0, rv, result);
      end
      total++;
      if (dut.r_lfsr !== 16'hACE1) begin
         bad++;
         $display("FAIL midroll_lfsr: got %h want ace1", dut.r_lfsr);
      end
`ifdef DICE_LED_BAR_EN
      total++;
      if (led_bar !== 10'd0) begin
         bad++;
         $display("FAIL midroll_led: got %h want 000", led_bar);
      end
`endif
      last_val = 0;
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (60) @(negedge clk);
      total++;
      if (rv_count !== rvc || busy !== 1'b0 || hex0 !== 7'h7F) begin
         bad++;
         $display("FAIL midroll_after: pulses=%0d busy=%b hex0=%h want %0d 0 7f", rv_count, busy, hex0, rvc);
      end
   endtask

   initial begin
      test_reset();
      test_bounce();
      test_arbitration();
      test_clamp();
      test_ignore();
      test_reset_midroll();
      total++;
      if (rv_count !== 5) begin
         bad++;
         $display("FAIL rv_pulses: got %0d want 5", rv_count);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
